ram_rd_stream: RTL

// - Read-burst engine directly upstream and downstream of the 4K x 64 dual-port RAM read port.
// - Accepts one burst command (start address, length) and issues one RAM read per cycle.
// - Captures returned words on the RAM data_valid flag into a response FIFO.
// - Presents the words as a valid/ready stream to the consumer (DMA/SoC bus side).
// - Credit-based issue: a read is issued only if FIFO space is guaranteed, so no word is ever dropped.

---
 rtl/ram_rd_stream.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ram_rd_stream.sv
// ram_rd_stream: burst read engine in front of a dual-port RAM read port.
// Issues one read per cycle while FIFO space is guaranteed, captures the
// returned words into a small first-word fall-through FIFO and presents them
// as a valid/ready stream with a last marker and a done pulse.
module ram_rd_stream #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 12,
  parameter int FIFO_D = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len_m1,
  output logic              ram_read,
  output logic [ADDR_W-1:0] ram_rd_address,
  input  logic [DATA_W-1:0] ram_data_out,
  input  logic              ram_data_valid,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = $clog2(FIFO_D);
  localparam int CNT_W = PTR_W + 1;
  localparam int LEN_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(FIFO_D);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  remaining, burst_len, ret_cnt;
  logic [CNT_W-1:0]  inflight, count;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [DATA_W:0]   mem [FIFO_D];
  logic              cmd_fire, issue, capture, pop, push_last;

  assign cmd_fire  = cmd_valid & cmd_ready;
  // Credit: words already buffered plus words still on their way from the RAM
  // must leave room for one more, so a returning word always has a slot.
  assign issue     = (state == ISSUE) && ((count + inflight) < DEPTH);
  // Returns arriving with nothing outstanding are leftovers from an aborted burst.
  assign capture   = ram_data_valid && (inflight != '0);
  assign pop       = m_valid & m_ready;
  assign push_last = (ret_cnt + LEN_W'(1)) == burst_len;

  assign m_valid = (count != '0);
  assign m_data  = m_valid ? mem[rd_ptr][DATA_W-1:0] : '0;
  assign m_last  = m_valid & mem[rd_ptr][DATA_W];

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode and control outputs
  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_nx = ISSUE;
      end
      ISSUE: begin
        if (issue && (remaining == LEN_W'(1))) state_nx = DRAIN;
      end
      DRAIN: begin
        if ((inflight == '0) && (count == '0) && (ret_cnt == burst_len)) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Burst bookkeeping, registered RAM read port and FIFO occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_addr       <= '0;
      remaining      <= '0;
      burst_len      <= '0;
      ret_cnt        <= '0;
      ram_read       <= 1'b0;
      ram_rd_address <= '0;
      inflight       <= '0;
      count          <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
    end else begin
      ram_read <= issue;
      if (cmd_fire) begin
        cur_addr  <= cmd_addr;
        remaining <= {1'b0, cmd_len_m1} + LEN_W'(1);
        burst_len <= {1'b0, cmd_len_m1} + LEN_W'(1);
        ret_cnt   <= '0;
      end else begin
        if (issue) begin
          ram_rd_address <= cur_addr;
          cur_addr       <= cur_addr + ADDR_W'(1);
          remaining      <= remaining - LEN_W'(1);
        end
        if (capture) ret_cnt <= ret_cnt + LEN_W'(1);
      end
      case ({issue, capture})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
      case ({capture, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (capture) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // FIFO storage; the last flag rides alongside each word
  always_ff @(posedge clk) begin
    if (capture) mem[wr_ptr] <= {push_last, ram_data_out};
  end

  // A push into a full FIFO without a simultaneous pop would lose a word.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(capture && (count == DEPTH) && !pop));

  // The RAM returns data a fixed number of cycles after sampling a read.
  a_rd_latency: assert property (@(posedge clk) disable iff (!rst_n)
    ram_read |-> ##RD_LAT ram_data_valid);

endmodule
